aes_key_sched_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 61 ++++++
 rtl/aes_key_word_step.sv | 30 +++
 rtl/aes_key_sched_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box substitution, word rotation, round constants, key-schedule state.
// Latency: pure functions and types, no state.
// Backpressure: none.
package aes_pkg;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_DONE
    } key_sched_state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte 0 of a word sits in bits [31:24].
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Round constant, indexed from 1.
    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic int nk_words_total(input int nk);
        return 4 * (nk + 7);
    endfunction

endpackage

// File: rtl/aes_key_word_step.sv
// One key-schedule word step: w_next = w_back ^ f(w_prev, k, rc).
// Latency: combinational.
// Backpressure: none.
module aes_key_word_step
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int KW = $clog2(Nk)
) (
    input  logic [31:0]   w_prev,
    input  logic [31:0]   w_back,
    input  logic [KW-1:0] k,
    input  logic [3:0]    rc,
    output logic [31:0]   w_next
);

    logic [31:0] t;

    // First word of each Nk group gets the rotate/substitute/rcon mix; AES-256 adds a mid-group substitution.
    always_comb begin
        t = w_prev;
        if (k == '0) begin
            t = sub_word(rot_word(w_prev)) ^ {rcon(rc), 24'h0};
        end else if ((Nk > 6) && (32'(k) == 32'd4)) begin
            t = sub_word(w_prev);
        end
        w_next = w_back ^ t;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES key schedule: one word per cycle into a local store, round keys served on a req/gnt port.
// Latency: NW-Nk cycles to full schedule after key accept; read data one cycle after grant.
// Backpressure: key_ready low while expanding; reads are held by the requester until their round is written.
`ifndef AES_EN_FF
`define AES_EN_FF(q_, d_, en_, clk_) \
    always_ff @(posedge clk_) begin \
        if (en_) q_ <= d_; \
    end
`endif

module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6,
    parameter int NW = nk_words_total(Nk)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_valid,
    output logic                     key_ready,
    input  logic [32*Nk-1:0]         key,
    output logic                     busy,
    output logic                     sched_done,
    input  logic                     rd_req,
    input  logic [$clog2(Nr+1)-1:0]  rd_round,
    output logic                     rd_gnt,
    output logic                     rd_valid,
    output logic [127:0]             rd_data
);

    localparam int JW = $clog2(NW + 1);
    localparam int AW = $clog2(NW);
    localparam int KW = $clog2(Nk);

    key_sched_state_t state;
    logic [JW-1:0]    j;
    logic [KW-1:0]    k;
    logic [3:0]       rc;

    logic [31:0]      w_store [NW];
    logic [31:0]      w_next;
    logic [AW-1:0]    prev_idx;
    logic [AW-1:0]    back_idx;
    logic [AW-1:0]    rd_base;
    logic             key_acc;
    logic             expanding;
    logic             last_word;
    logic             rd_in_range;
    logic             rd_avail;

    assign key_acc   = key_valid & key_ready;
    assign expanding = (state == KS_EXPAND);
    assign last_word = (j == JW'(NW - 1));
    assign prev_idx  = AW'(j - JW'(1));
    assign back_idx  = AW'(j - JW'(Nk));

    aes_key_word_step #(.Nk(Nk)) u_step (
        .w_prev (w_store[prev_idx]),
        .w_back (w_store[back_idx]),
        .k      (k),
        .rc     (rc),
        .w_next (w_next)
    );

    // j counts words already written, so round r is complete once j passes its last word.
    assign rd_in_range = (int'(rd_round) <= Nr);
    assign rd_avail    = (state == KS_DONE) || (int'(j) > 4 * int'(rd_round) + 3);
    assign rd_gnt      = rd_req & rd_avail & rd_in_range;
    assign rd_base     = rd_in_range ? AW'(4 * int'(rd_round)) : '0;

    // Control FSM: accept key, step j/k/rc once per expansion cycle, flag completion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= KS_IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            sched_done <= 1'b0;
            j          <= '0;
            k          <= '0;
            rc         <= '0;
        end else begin
            case (state)
                KS_IDLE, KS_DONE: begin
                    if (key_valid) begin
                        state      <= KS_EXPAND;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        sched_done <= 1'b0;
                        j          <= JW'(Nk);
                        k          <= '0;
                        rc         <= 4'd1;
                    end
                end
                KS_EXPAND: begin
                    j <= j + JW'(1);
                    k <= (k == KW'(Nk - 1)) ? '0 : k + KW'(1);
                    if (k == '0) begin
                        rc <= rc + 4'd1;
                    end
                    if (last_word) begin
                        state      <= KS_DONE;
                        key_ready  <= 1'b1;
                        busy       <= 1'b0;
                        sched_done <= 1'b1;
                    end
                end
                default: state <= KS_IDLE;
            endcase
        end
    end

    // Word store: key words load on accept, later words load when j points at them.
    for (genvar i = 0; i < NW; i++) begin : g_word
        logic        word_en;
        logic [31:0] word_d;
        logic [31:0] word_q;
        if (i < Nk) begin : g_key
            assign word_en = key_acc;
            assign word_d  = key[32*i +: 32];
        end else begin : g_exp
            assign word_en = expanding && (j == JW'(i));
            assign word_d  = w_next;
        end
        // Per-word enable flop, no reset on the data path.
        `AES_EN_FF(word_q, word_d, word_en, clk)
        assign w_store[i] = word_q;
    end

    // Read port: capture the granted round; a same-edge key load still reads the old words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_gnt;
            if (rd_gnt) begin
                rd_data <= {w_store[rd_base + AW'(3)], w_store[rd_base + AW'(2)],
                            w_store[rd_base + AW'(1)], w_store[rd_base]};
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl at Nk=4,6,8 against a word-count reference model.
// Latency: checks sched_done timing, early-read stall and one-cycle read latency.
// Backpressure: key_valid held through expansion; out-of-range and unwritten rounds must not be granted.
module tb_aes_key_sched_ctrl;

    logic          clk = 1'b0;
    logic          reset;
    logic          key_valid  [3];
    logic [255:0]  key_bus    [3];
    logic          key_ready  [3];
    logic          busy       [3];
    logic          sched_done [3];
    logic          rd_req     [3];
    logic [3:0]    rd_round   [3];
    logic          rd_gnt     [3];
    logic          rd_valid   [3];
    logic [127:0]  rd_data    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_sched_ctrl #(.Nk(4 + 2*g)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .key_valid  (key_valid[g]),
            .key_ready  (key_ready[g]),
            .key        (key_bus[g][32*(4+2*g)-1:0]),
            .busy       (busy[g]),
            .sched_done (sched_done[g]),
            .rd_req     (rd_req[g]),
            .rd_round   (rd_round[g]),
            .rd_gnt     (rd_gnt[g]),
            .rd_valid   (rd_valid[g]),
            .rd_data    (rd_data[g])
        );
    end

    // Reference model state: expanded schedule, words available so far, last read data.
    logic [7:0]   sbox_m [256];
    logic [31:0]  mw     [3][60];
    bit           m_loaded [3];
    int           m_words  [3];
    logic [127:0] m_data   [3];

    int n_pass   = 0;
    int n_checks = 0;
    bit seen_gnt;
    int first_gnt;
    int done_at;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon_m(input int i);
        logic [7:0] r = 8'h01;
        for (int n = 1; n < i; n++) r = xtime(r);
        return r;
    endfunction

    task automatic model_load(input int g, input logic [255:0] kk);
        int nk = 4 + 2*g;
        int nw = 4 * (nk + 7);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) mw[g][i] = kk[32*i +: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[g][i-1];
            if (i % nk == 0) t = sub_m({t[23:0], t[31:24]}) ^ {rcon_m(i / nk), 24'h0};
            else if (nk > 6 && i % nk == 4) t = sub_m(t);
            mw[g][i] = mw[g][i-nk] ^ t;
        end
    endtask

    function automatic bit m_busy(input int g);
        return m_loaded[g] && (m_words[g] < 4 * (4 + 2*g + 7));
    endfunction

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: inputs already driven; checks grant before the edge and all registered outputs after.
    task automatic tick(input int g);
        int nk = 4 + 2*g;
        int nw = 4 * (nk + 7);
        int nr = nk + 6;
        int r;
        bit gnt_e;
        bit acc;
        logic [255:0] kk;
        #1;
        r = int'(rd_round[g]);
        gnt_e = rd_req[g] && (r <= nr) && m_loaded[g] && (4*r + 3 < m_words[g]);
        seen_gnt = rd_gnt[g];
        check("rd_gnt", 128'(rd_gnt[g]), 128'(gnt_e));
        if (gnt_e) m_data[g] = {mw[g][4*r+3], mw[g][4*r+2], mw[g][4*r+1], mw[g][4*r]};
        acc = key_valid[g] && !m_busy(g);
        kk  = key_bus[g];
        @(posedge clk);
        #1;
        if (acc) begin
            model_load(g, kk);
            m_loaded[g] = 1'b1;
            m_words[g]  = nk;
        end else if (m_busy(g)) begin
            m_words[g]++;
        end
        check("rd_valid",   128'(rd_valid[g]),   128'(gnt_e));
        check("rd_data",    rd_data[g],          m_data[g]);
        check("key_ready",  128'(key_ready[g]),  128'(!m_busy(g)));
        check("busy",       128'(busy[g]),       128'(m_busy(g)));
        check("sched_done", 128'(sched_done[g]), 128'(m_loaded[g] && m_words[g] == nw));
    endtask

    task automatic accept(input int g, input logic [255:0] kk);
        key_valid[g] = 1'b1;
        key_bus[g]   = kk;
        tick(g);
        first_gnt = seen_gnt ? 1 : -1;
        done_at   = -1;
    endtask

    // Run to completion with key_valid held and a changing key; hold_round >= 0 holds that read until granted.
    task automatic drain(input int g, input int hold_round);
        int n = 1;
        while (m_busy(g) && n < 200) begin
            n++;
            key_valid[g] = 1'b1;
            key_bus[g]   = rand_key();
            if (hold_round >= 0 && first_gnt < 0) begin
                rd_req[g]   = 1'b1;
                rd_round[g] = 4'(hold_round);
            end else begin
                rd_req[g]   = 1'($urandom_range(0, 1));
                rd_round[g] = 4'($urandom_range(0, 15));
            end
            tick(g);
            if (seen_gnt && first_gnt < 0) first_gnt = n;
            if (sched_done[g] && done_at < 0) done_at = n;
        end
        check("drain_bound", 128'(n < 200), 128'(1));
        key_valid[g] = 1'b0;
        rd_req[g]    = 1'b0;
    endtask

    task automatic read_check(input int g, input int r, input logic [127:0] exp,
                              input logic [127:0] mask, input string tag);
        key_valid[g] = 1'b0;
        rd_req[g]    = 1'b1;
        rd_round[g]  = 4'(r);
        tick(g);
        check(tag, rd_data[g] & mask, exp & mask);
        rd_req[g] = 1'b0;
    endtask

    task automatic model_reset();
        for (int g = 0; g < 3; g++) begin
            m_loaded[g] = 1'b0;
            m_words[g]  = 0;
            m_data[g]   = '0;
        end
    endtask

    localparam logic [127:0] W_LO  = {96'h0, 32'hffffffff};
    localparam logic [127:0] W_HI  = {32'hffffffff, 96'h0};
    localparam logic [127:0] W_2   = {32'h0, 32'hffffffff, 64'h0};
    localparam logic [127:0] R10_4 = 128'hb6630ca6e13f0cc8c9ee2589d014f9a8;

    logic [255:0] k4, k6, k8;

    initial begin
        k4 = 256'({32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516});
        k6 = 256'({32'h522c6b7b, 32'h62f8ead2, 32'h809079e5, 32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7});
        k8 = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
              32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};
        build_sbox();
        model_reset();
        for (int g = 0; g < 3; g++) begin
            key_valid[g] = 1'b0;
            key_bus[g]   = '0;
            rd_req[g]    = 1'b0;
            rd_round[g]  = '0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            check("rst_key_ready",  128'(key_ready[g]),  128'(1));
            check("rst_busy",       128'(busy[g]),       128'(0));
            check("rst_sched_done", 128'(sched_done[g]), 128'(0));
            check("rst_rd_valid",   128'(rd_valid[g]),   128'(0));
            check("rst_rd_data",    rd_data[g],          128'(0));
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nk=4 from idle with round 3 held: grant appears once j reaches 16, i.e. 14th cycle counting acceptance.
        rd_req[0]   = 1'b1;
        rd_round[0] = 4'd3;
        accept(0, k4);
        drain(0, 3);
        check("early_gnt_cycle", 128'(first_gnt), 128'(16 - 4 + 2));
        check("done_lat_nk4",    128'(done_at),   128'(41));
        read_check(0, 1,  128'ha0fafe17, W_LO, "nk4_w4");
        read_check(0, 10, R10_4, {128{1'b1}}, "nk4_round10");
        read_check(0, 11, '0, '0, "nk4_round11");
        check("nk4_round11_gnt", 128'(seen_gnt), 128'(0));

        // Re-key in DONE with a concurrent read: old schedule data comes back.
        rd_req[0]   = 1'b1;
        rd_round[0] = 4'd10;
        accept(0, rand_key());
        check("rekey_gnt",      128'(seen_gnt), 128'(1));
        check("rekey_old_data", rd_data[0],     R10_4);
        rd_req[0] = 1'b0;
        drain(0, -1);
        for (int i = 0; i < 4; i++) read_check(0, $urandom_range(0, 10), '0, '0, "rand_read");

        // Reset mid-expansion at j=20, then reload the known key.
        accept(0, k4);
        for (int n = 0; n < 100 && m_words[0] < 20; n++) begin
            key_bus[0]  = rand_key();
            rd_req[0]   = 1'($urandom_range(0, 1));
            rd_round[0] = 4'($urandom_range(0, 4));
            tick(0);
        end
        check("reached_j20", 128'(m_words[0]), 128'(20));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_key_ready",  128'(key_ready[0]),  128'(1));
        check("arst_busy",       128'(busy[0]),       128'(0));
        check("arst_sched_done", 128'(sched_done[0]), 128'(0));
        check("arst_rd_valid",   128'(rd_valid[0]),   128'(0));
        check("arst_rd_data",    rd_data[0],          128'(0));
        model_reset();
        key_valid[0] = 1'b0;
        rd_req[0]    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        rd_req[0]   = 1'b1;
        rd_round[0] = 4'd0;
        accept(0, k4);
        check("post_rst_no_gnt", 128'(seen_gnt), 128'(0));
        drain(0, -1);
        read_check(0, 10, R10_4, {128{1'b1}}, "reload_round10");

        // Nk=6.
        accept(1, k6);
        drain(1, -1);
        check("done_lat_nk6", 128'(done_at), 128'(47));
        read_check(1, 1,  {32'h0, 32'hfe0c91f7, 64'h0}, W_2,  "nk6_w6");
        read_check(1, 12, {32'h01002202, 96'h0},        W_HI, "nk6_w51");
        read_check(1, 13, '0, '0, "nk6_round13");
        check("nk6_round13_gnt", 128'(seen_gnt), 128'(0));

        // Nk=8, including the mid-group substitution word w[12].
        accept(2, k8);
        drain(2, -1);
        check("done_lat_nk8", 128'(done_at), 128'(53));
        read_check(2, 2,  128'h9ba35411,         W_LO, "nk8_w8");
        read_check(2, 3,  128'ha8b09c1a,         W_LO, "nk8_w12");
        read_check(2, 14, {32'h706c631e, 96'h0}, W_HI, "nk8_w59");
        for (int i = 0; i < 4; i++) read_check(2, $urandom_range(0, 15), '0, '0, "rand_read8");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
        $fatal(1);
    end

endmodule
